// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared constants and types for the multiplexed seven-segment display path.
//   SEG_W, SEG_BLANK : segment bus width and the all-off pattern
//   DEF_*            : default parameter values for led_scan_pwm
//   seg_pat_t        : one digit's segment pattern plus decimal point
// -----------------------------------------------------------------------------
package disp_pkg;

  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0;

  localparam int DEF_NUM_DIGITS = 6;
  localparam int DEF_SCAN_DIV   = 5000;
  localparam int DEF_BRIGHT_W   = 3;
  localparam int DEF_BLINK_DIV  = 25000000;

  typedef struct packed {
    logic [SEG_W-1:0] seg;
    logic             dp;
  } seg_pat_t;

endpackage

// File: rtl/tick_div.sv
// -----------------------------------------------------------------------------
// tick_div
// Free-running divider: tick_o is high for one clk cycle out of every DIV.
// The first tick appears DIV-1 cycles after reset release.
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   tick_o : one-cycle tick
// -----------------------------------------------------------------------------
module tick_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks assign every output on every path so no latch
  // is inferred; here the ternary covers both cases.
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/led_scan_pwm.sv
// -----------------------------------------------------------------------------
// led_scan_pwm
// Time-multiplexed seven-segment driver with PWM brightness and per-digit
// blink. Each digit owns a slot of SCAN_DIV cycles split into 2**BRIGHT_W
// equal phases; a digit is lit in phases below the brightness code (or in all
// phases at full code). Segment data, brightness and blink state are frozen
// at the first cycle of each slot. All outputs are registered.
//   clk, rst        : system clock, asynchronous active-high reset
//   i_enable        : 1 = scan, 0 = dark with counters held at zero
//   i_digit_seg     : SEG_W bits per digit, digit d at [7d+6:7d]
//   i_dp            : decimal point per digit
//   i_blink_mask    : digits that go dark in the blink-on half-period
//   i_bright        : brightness code, 0 = dark, all ones = full on
//   o_seg, o_seg_dp : active-high segments / decimal point of current digit
//   o_seg_enb       : active-low one-hot digit common enable
//   o_frame_start   : pulse with the first output of each digit-0 slot
// -----------------------------------------------------------------------------
module led_scan_pwm
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int SCAN_DIV   = DEF_SCAN_DIV,
  parameter int BRIGHT_W   = DEF_BRIGHT_W,
  parameter int BLINK_DIV  = DEF_BLINK_DIV
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_enable,
  input  logic [SEG_W*NUM_DIGITS-1:0] i_digit_seg,
  input  logic [NUM_DIGITS-1:0]       i_dp,
  input  logic [NUM_DIGITS-1:0]       i_blink_mask,
  input  logic [BRIGHT_W-1:0]         i_bright,
  output logic [SEG_W-1:0]            o_seg,
  output logic                        o_seg_dp,
  output logic [NUM_DIGITS-1:0]       o_seg_enb,
  output logic                        o_frame_start
);

  localparam int SLOT_W    = $clog2(SCAN_DIV);
  localparam int DIG_W     = $clog2(NUM_DIGITS);
  localparam int PHASE_LEN = SCAN_DIV >> BRIGHT_W;
  localparam int PCNT_W    = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PHASE_LEN - 1);

  // Scan counters. The phase index is tracked with its own sub-counter so no
  // divider is needed for slot_cnt / PHASE_LEN.
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [DIG_W-1:0]    digit_q, digit_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [BRIGHT_W-1:0] phase_q, phase_d;

  // Per-slot snapshots.
  seg_pat_t            snap_q, snap_d;
  logic [BRIGHT_W-1:0] bright_q, bright_d;
  logic                bdark_q, bdark_d;

  // Blink half-period state.
  logic blink_q;
  logic blink_tick;

  // Output registers.
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] enb_q, enb_d;
  logic                  frame_q, frame_d;

  seg_pat_t            live_pat, cur_pat;
  logic                live_mask;
  logic                slot_start;
  logic [BRIGHT_W-1:0] cur_bright;
  logic                cur_bdark;
  logic                lit;

  tick_div #(
    .DIV (BLINK_DIV)
  ) u_blink_div (
    .clk    (clk),
    .rst    (rst),
    .tick_o (blink_tick)
  );

  // The blink divider and phase bit keep running while the scan is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             blink_q <= 1'b0;
    else if (blink_tick) blink_q <= ~blink_q;
  end

  // Pick the current digit's live inputs.
  always_comb begin
    live_pat.seg = SEG_BLANK;
    live_pat.dp  = 1'b0;
    live_mask    = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (digit_q == DIG_W'(d)) begin
        live_pat.seg = i_digit_seg[SEG_W*d +: SEG_W];
        live_pat.dp  = i_dp[d];
        live_mask    = i_blink_mask[d];
      end
    end
  end

  // Counter next state. Disable parks everything at zero so re-enable starts
  // a fresh digit-0 slot.
  always_comb begin
    slot_d  = slot_q;
    digit_d = digit_q;
    pcnt_d  = pcnt_q;
    phase_d = phase_q;
    if (!i_enable) begin
      slot_d  = '0;
      digit_d = '0;
      pcnt_d  = '0;
      phase_d = '0;
    end else if (slot_q == SLOT_LAST) begin
      slot_d  = '0;
      pcnt_d  = '0;
      phase_d = '0;
      digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
    end else begin
      slot_d = slot_q + 1'b1;
      if (pcnt_q == PCNT_LAST) begin
        pcnt_d  = '0;
        phase_d = phase_q + 1'b1;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  // On the first slot cycle the live values are used and captured; for the
  // rest of the slot the captured copy drives the display. Reloading the
  // snapshot with cur_* every cycle is equivalent and needs no load enable.
  assign slot_start = (slot_q == '0);
  assign cur_pat    = slot_start ? live_pat : snap_q;
  assign cur_bright = slot_start ? i_bright : bright_q;
  assign cur_bdark  = slot_start ? (blink_q & live_mask) : bdark_q;
  assign snap_d     = cur_pat;
  assign bright_d   = cur_bright;
  assign bdark_d    = cur_bdark;

  assign lit = i_enable && !cur_bdark && ((&cur_bright) || (phase_q < cur_bright));

  always_comb begin
    seg_d   = lit ? cur_pat.seg : SEG_BLANK;
    dp_d    = lit && cur_pat.dp;
    frame_d = i_enable && slot_start && (digit_q == '0);
    enb_d   = '1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (lit && (digit_q == DIG_W'(d))) enb_d[d] = 1'b0;
    end
  end

  // NOTE: snapshot registers are reset along with the counters even though
  // they are reloaded at every slot start; it keeps X out of simulation and
  // costs nothing at this width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q   <= '0;
      digit_q  <= '0;
      pcnt_q   <= '0;
      phase_q  <= '0;
      snap_q   <= '0;
      bright_q <= '0;
      bdark_q  <= 1'b0;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b0;
      enb_q    <= '1;
      frame_q  <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      digit_q  <= digit_d;
      pcnt_q   <= pcnt_d;
      phase_q  <= phase_d;
      snap_q   <= snap_d;
      bright_q <= bright_d;
      bdark_q  <= bdark_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      enb_q    <= enb_d;
      frame_q  <= frame_d;
    end
  end

  assign o_seg         = seg_q;
  assign o_seg_dp      = dp_q;
  assign o_seg_enb     = enb_q;
  assign o_frame_start = frame_q;

endmodule
